// File: rtl/reg_desp_n.sv
// reg_desp_n: parametrised universal shift register with logical/arithmetic shift,
// rotate, load, hold and an autonomous serialise (burst) mode with busy/done status.
module reg_desp_n #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             dir,
  input  logic             s_in,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             s_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    M_LSH   = 3'b000,
    M_ROT   = 3'b001,
    M_LOAD  = 3'b010,
    M_HOLD  = 3'b011,
    M_ASH   = 3'b100,
    M_BURST = 3'b101
  } mode_t;

  localparam logic [CW-1:0] LP_CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(1);

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_q, w_q_nx;
  logic             r_sout, w_sout_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic             r_bdir, w_bdir_nx;
  logic             r_done, w_done_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_sout  <= 1'b0;
      r_cnt   <= '0;
      r_bdir  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_q     <= w_q_nx;
      r_sout  <= w_sout_nx;
      r_cnt   <= w_cnt_nx;
      r_bdir  <= w_bdir_nx;
      r_done  <= w_done_nx;
    end
  end

  // done is a pulse: it defaults low every edge, even while enb is low
  always_comb begin
    w_state_nx = r_state;
    w_q_nx     = r_q;
    w_sout_nx  = r_sout;
    w_cnt_nx   = r_cnt;
    w_bdir_nx  = r_bdir;
    w_done_nx  = 1'b0;

    if (enb) begin
      if (r_state == ST_SHIFT) begin
        if (r_bdir) begin
          w_q_nx    = {s_in, r_q[WIDTH-1:1]};
          w_sout_nx = r_q[0];
        end else begin
          w_q_nx    = {r_q[WIDTH-2:0], s_in};
          w_sout_nx = r_q[WIDTH-1];
        end
        w_cnt_nx = r_cnt - CW'(1);
        if (r_cnt == LP_CNT_LAST) begin
          w_state_nx = ST_IDLE;
          w_done_nx  = 1'b1;
        end
      end else begin
        case (mode)
          M_LSH: begin
            if (dir) begin
              w_q_nx    = {s_in, r_q[WIDTH-1:1]};
              w_sout_nx = r_q[0];
            end else begin
              w_q_nx    = {r_q[WIDTH-2:0], s_in};
              w_sout_nx = r_q[WIDTH-1];
            end
          end
          M_ROT: begin
            w_q_nx    = dir ? {r_q[0], r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            w_sout_nx = 1'b0;
          end
          M_LOAD: begin
            w_q_nx    = d;
            w_sout_nx = 1'b0;
          end
          M_ASH: begin
            if (dir) begin
              w_q_nx    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
              w_sout_nx = r_q[0];
            end else begin
              w_q_nx    = {r_q[WIDTH-2:0], 1'b0};
              w_sout_nx = r_q[WIDTH-1];
            end
          end
          M_BURST: begin
            w_q_nx     = d;
            w_sout_nx  = 1'b0;
            w_cnt_nx   = LP_CNT_INIT;
            w_bdir_nx  = dir;
            w_state_nx = ST_SHIFT;
          end
          M_HOLD: begin
            w_q_nx = r_q;
          end
          default: begin
            w_q_nx = r_q;
          end
        endcase
      end
    end
  end

  assign q     = r_q;
  assign s_out = r_sout;
  assign busy  = (r_state == ST_SHIFT);
  assign done  = r_done;

endmodule

// File: tb/tb_reg_desp_n.sv
// Self-checking bench for reg_desp_n at WIDTH=2, 8 and 16 using an expected-value
// queue: expectations are pushed as stimulus is planned and popped after each edge.
module tb_reg_desp_n;

  logic        clk = 1'b0;
  logic        rst_n, enb, dir, s_in;
  logic [2:0]  mode;
  logic [15:0] d;
  logic [1:0]  q2;
  logic [7:0]  q8;
  logic [15:0] q16;
  logic        so2, so8, so16, b2, b8, b16, dn2, dn8, dn16;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          w;
    logic [18:0] v;
  } exp_t;

  typedef struct {
    logic [2:0]  m;
    logic        dr;
    logic        si;
    logic        en;
    logic [15:0] dv;
    logic [15:0] eq;
    logic        eso;
  } step_t;

  exp_t sb[$];

  reg_desp_n #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .enb(enb), .dir(dir), .s_in(s_in), .mode(mode),
    .d(d[1:0]), .q(q2), .s_out(so2), .busy(b2), .done(dn2));

  reg_desp_n #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .enb(enb), .dir(dir), .s_in(s_in), .mode(mode),
    .d(d[7:0]), .q(q8), .s_out(so8), .busy(b8), .done(dn8));

  reg_desp_n #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .enb(enb), .dir(dir), .s_in(s_in), .mode(mode),
    .d(d), .q(q16), .s_out(so16), .busy(b16), .done(dn16));

  always #5 clk = ~clk;

  function automatic logic [18:0] ex(input logic [15:0] eq, input logic so, input logic bz,
                                     input logic dn);
    return {eq, so, bz, dn};
  endfunction

  function automatic logic [18:0] obs(input int w);
    case (w)
      2:       return {14'b0, q2, so2, b2, dn2};
      8:       return {8'b0, q8, so8, b8, dn8};
      default: return {q16, so16, b16, dn16};
    endcase
  endfunction

  function automatic string fmt(input logic [18:0] v);
    return $sformatf("q=%h s_out=%b busy=%b done=%b", v[18:3], v[2], v[1], v[0]);
  endfunction

  task automatic pushE(input string tag, input int w, input logic [18:0] v);
    exp_t e;
    e.tag = tag;
    e.w   = w;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    enb   = 1'b0;
    mode  = 3'b011;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [18:0] act;
    rst_n = 1'b1; enb = 1'b1; mode = 3'b010; d = 16'h00A5; dir = 1'b0; s_in = 1'b0;
    pushE("reset_preload", 8, ex(16'h00A5, 1'b0, 1'b0, 1'b0));
    pushE("reset_clear", 8, ex(16'h0000, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) begin
      if (i == 1) rst_n = 1'b0;
      tick();
      e = sb.pop_front(); act = obs(e.w); checks++;
      if (act !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %s want %s", e.tag, fmt(act), fmt(e.v));
      end
    end
    rst_n = 1'b1;
  endtask

  // each op is preceded by a load of the given preset value
  task automatic test_shift(input int w, input logic [15:0] pre, input step_t ops[$]);
    exp_t e;
    logic [18:0] act;
    foreach (ops[i]) begin
      pushE($sformatf("shift_w%0d_load%0d", w, i), w, ex(pre, 1'b0, 1'b0, 1'b0));
      pushE($sformatf("shift_w%0d_op%0d", w, i), w, ex(ops[i].eq, ops[i].eso, 1'b0, 1'b0));
      enb = 1'b1; mode = 3'b010; d = pre;
      tick();
      e = sb.pop_front(); act = obs(e.w); checks++;
      if (act !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %s want %s", e.tag, fmt(act), fmt(e.v));
      end
      mode = ops[i].m; dir = ops[i].dr; s_in = ops[i].si; enb = ops[i].en; d = ops[i].dv;
      tick();
      e = sb.pop_front(); act = obs(e.w); checks++;
      if (act !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %s want %s", e.tag, fmt(act), fmt(e.v));
      end
    end
  endtask

  task automatic test_rotate_hold();
    step_t seq[$];
    exp_t e;
    logic [18:0] act;
    seq = '{
      '{3'b010, 1'b0, 1'b0, 1'b1, 16'h0081, 16'h0081, 1'b0},
      '{3'b000, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0040, 1'b1},
      '{3'b011, 1'b0, 1'b1, 1'b1, 16'h00FF, 16'h0040, 1'b1},
      '{3'b110, 1'b0, 1'b1, 1'b1, 16'h00FF, 16'h0040, 1'b1},
      '{3'b111, 1'b1, 1'b1, 1'b1, 16'h00FF, 16'h0040, 1'b1},
      '{3'b010, 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0040, 1'b1},
      '{3'b010, 1'b0, 1'b0, 1'b1, 16'h0081, 16'h0081, 1'b0},
      '{3'b001, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0003, 1'b0},
      '{3'b010, 1'b0, 1'b0, 1'b1, 16'h0081, 16'h0081, 1'b0},
      '{3'b001, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h00C0, 1'b0}
    };
    foreach (seq[i]) pushE($sformatf("rot_hold_%0d", i), 8, ex(seq[i].eq, seq[i].eso, 1'b0, 1'b0));
    foreach (seq[i]) begin
      mode = seq[i].m; dir = seq[i].dr; s_in = seq[i].si; enb = seq[i].en; d = seq[i].dv;
      tick();
      e = sb.pop_front(); act = obs(e.w); checks++;
      if (act !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %s want %s", e.tag, fmt(act), fmt(e.v));
      end
    end
    enb = 1'b1;
  endtask

  // full burst with s_in=0; mode/d/dir are scrambled while shifting
  task automatic test_burst(input int w, input logic [15:0] dv, input logic dr);
    exp_t e;
    logic [18:0] act;
    logic [15:0] msk, dd, eq;
    logic        eso;
    msk = (w == 16) ? 16'hFFFF : 16'((32'd1 << w) - 1);
    dd  = dv & msk;
    pushE($sformatf("burst_w%0d_E0", w), w, ex(dd, 1'b0, 1'b1, 1'b0));
    for (int k = 1; k <= w; k++) begin
      eq  = dr ? (dd >> k) : ((dd << k) & msk);
      eso = dr ? dd[k-1] : dd[w-k];
      pushE($sformatf("burst_w%0d_E%0d", w, k), w, ex(eq, eso, k < w, k == w));
    end
    pushE($sformatf("burst_w%0d_after", w), w, ex(16'h0000, dr ? dd[w-1] : dd[0], 1'b0, 1'b0));
    enb = 1'b1; s_in = 1'b0; mode = 3'b101; d = dv; dir = dr;
    tick();
    e = sb.pop_front(); act = obs(e.w); checks++;
    if (act !== e.v) begin
      errors++;
      $display("[TB] FAIL %s: got %s want %s", e.tag, fmt(act), fmt(e.v));
    end
    mode = 3'b010; d = 16'hFFFF; dir = ~dr;
    for (int k = 1; k <= w + 1; k++) begin
      if (k == 3) mode = 3'b101;
      if (k == w + 1) mode = 3'b011;
      tick();
      e = sb.pop_front(); act = obs(e.w); checks++;
      if (act !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %s want %s", e.tag, fmt(act), fmt(e.v));
      end
    end
  endtask

  task automatic test_stall_restart();
    exp_t e;
    logic [18:0] act;
    logic [7:0]  dd;
    int          k;
    dd = 8'hF0;
    pushE("stall_E0", 8, ex({8'h00, dd}, 1'b0, 1'b1, 1'b0));
    for (int ed = 1; ed <= 11; ed++) begin
      k = (ed <= 2) ? ed : ((ed <= 5) ? 2 : ed - 3);
      pushE($sformatf("stall_edge%0d", ed), 8,
            ex({8'h00, 8'(dd << k)}, dd[8-k], k < 8, (ed == 11)));
    end
    pushE("restart_E0", 8, ex(16'h003C, 1'b0, 1'b1, 1'b0));
    pushE("restart_E1", 8, ex(16'h001E, 1'b0, 1'b1, 1'b0));
    enb = 1'b1; s_in = 1'b0; mode = 3'b101; d = 16'h00F0; dir = 1'b0;
    for (int ed = 0; ed <= 13; ed++) begin
      enb = !(ed >= 3 && ed <= 5);
      if (ed == 1) begin mode = 3'b010; d = 16'h0000; end
      if (ed == 12) begin mode = 3'b101; d = 16'h003C; dir = 1'b1; end
      if (ed == 13) mode = 3'b011;
      tick();
      e = sb.pop_front(); act = obs(e.w); checks++;
      if (act !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %s want %s", e.tag, fmt(act), fmt(e.v));
      end
    end
    doReset();
  endtask

  task automatic test_reset_midburst();
    exp_t e;
    logic [18:0] act;
    pushE("midrst_E0", 8, ex(16'h00A5, 1'b0, 1'b1, 1'b0));
    pushE("midrst_E1", 8, ex(16'h0052, 1'b1, 1'b1, 1'b0));
    pushE("midrst_E2", 8, ex(16'h0029, 1'b0, 1'b1, 1'b0));
    pushE("midrst_E3", 8, ex(16'h0014, 1'b1, 1'b1, 1'b0));
    for (int i = 4; i <= 13; i++) pushE($sformatf("midrst_E%0d", i), 8, ex(16'h0000, 1'b0, 1'b0, 1'b0));
    enb = 1'b1; s_in = 1'b0; mode = 3'b101; d = 16'h00A5; dir = 1'b1;
    for (int ed = 0; ed <= 13; ed++) begin
      if (ed == 1) mode = 3'b011;
      rst_n = (ed != 4);
      tick();
      e = sb.pop_front(); act = obs(e.w); checks++;
      if (act !== e.v) begin
        errors++;
        $display("[TB] FAIL %s: got %s want %s", e.tag, fmt(act), fmt(e.v));
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    step_t ops[$];
    rst_n = 1'b0; enb = 1'b0; dir = 1'b0; s_in = 1'b0; mode = 3'b011; d = '0;
    tick();
    tick();
    rst_n = 1'b1;

    test_reset();

    ops = '{
      '{3'b000, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h00C0, 1'b1},
      '{3'b100, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h00C0, 1'b1},
      '{3'b100, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0002, 1'b1},
      '{3'b000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 1'b1}
    };
    test_shift(8, 16'h0081, ops);

    test_rotate_hold();
    test_burst(8, 16'h00B4, 1'b1);
    doReset();
    test_stall_restart();
    test_reset_midburst();

    ops = '{
      '{3'b000, 1'b1, 1'b1, 1'b1, 16'h0000, 16'hC000, 1'b1},
      '{3'b100, 1'b1, 1'b0, 1'b1, 16'h0000, 16'hC000, 1'b1},
      '{3'b100, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0002, 1'b1}
    };
    test_shift(16, 16'h8001, ops);
    ops = '{
      '{3'b100, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0002, 1'b1},
      '{3'b001, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0003, 1'b0},
      '{3'b100, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0003, 1'b1}
    };
    test_shift(2, 16'h0003, ops);

    doReset();
    test_burst(16, 16'hC3A5, 1'b1);
    doReset();
    test_burst(2, 16'h0002, 1'b0);
    doReset();
    test_burst(16, 16'h5A0F, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
